// File: rtl/lsu_dispatch_unit.sv
// -----------------------------------------------------------------------------
// lsu_dispatch_unit
//   Issue stage placed in front of the load/store unit. Accepts one load/store
//   op per handshake from the core, allocates the lowest free transaction tag,
//   and drives the LSU two-phase protocol (instruction phase, then data phase).
//   Tracks outstanding tags with a bitmap. LSU completions are buffered in a
//   response FIFO and returned to the core in completion order. A tag is
//   released only when its response is popped by the core.
//
// Ports
//   clk_in, rst_in            clock, asynchronous active-high reset
//   cs_N_in                   active-low enable; blocks new op acceptance only
//   op_*                      core op request (valid/ready, is_write, addr, value)
//   lsu_proc_instr_*          LSU instruction phase (valid/ready, tag, is_write)
//   lsu_proc_data_*, lsu_proc_addr, lsu_proc_value
//                             LSU data phase (valid/ready, tag, addr, value)
//   lsu_completion_*          LSU completion pulse (no backpressure)
//   resp_*                    response to core (valid/ready, tag, is_write, value)
//   outstanding_out           number of tags currently allocated
//   err_spurious_out          sticky flag: completion for a tag not outstanding
// -----------------------------------------------------------------------------
module lsu_dispatch_unit #(
   parameter int TAG_WIDTH       = 10,
   parameter int MAX_OUTSTANDING = 8
) (
   input  logic                                   clk_in,
   input  logic                                   rst_in,
   input  logic                                   cs_N_in,
   input  logic                                   op_valid_in,
   output logic                                   op_ready_out,
   input  logic                                   op_is_write_in,
   input  logic [63:0]                            op_addr_in,
   input  logic [63:0]                            op_value_in,
   output logic                                   lsu_proc_instr_valid,
   output logic [TAG_WIDTH-1:0]                   lsu_proc_instr_tag,
   output logic                                   lsu_proc_instr_is_write,
   input  logic                                   lsu_proc_instr_ready,
   output logic                                   lsu_proc_data_valid,
   output logic [TAG_WIDTH-1:0]                   lsu_proc_data_tag,
   output logic [63:0]                            lsu_proc_addr,
   output logic [63:0]                            lsu_proc_value,
   input  logic                                   lsu_proc_data_ready,
   input  logic                                   lsu_completion_valid,
   input  logic [TAG_WIDTH-1:0]                   lsu_completion_tag,
   input  logic [63:0]                            lsu_completion_value,
   output logic                                   resp_valid_out,
   input  logic                                   resp_ready_in,
   output logic [TAG_WIDTH-1:0]                   resp_tag_out,
   output logic                                   resp_is_write_out,
   output logic [63:0]                            resp_value_out,
   output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding_out,
   output logic                                   err_spurious_out
);

   localparam int IDX_W = $clog2(MAX_OUTSTANDING);
   localparam int CNT_W = $clog2(MAX_OUTSTANDING+1);

   typedef enum logic [1:0] {ST_IDLE, ST_INSTR, ST_DATA} state_e;

   state_e                     state_q;
   logic                       instr_valid_q;
   logic                       data_valid_q;
   logic [TAG_WIDTH-1:0]       cur_tag_q;
   logic                       cur_is_write_q;
   logic [63:0]                cur_addr_q;
   logic [63:0]                cur_value_q;

   logic [MAX_OUTSTANDING-1:0] bitmap_q, bitmap_d;
   logic [MAX_OUTSTANDING-1:0] completed_q, completed_d;
   logic [MAX_OUTSTANDING-1:0] is_write_tbl_q, is_write_tbl_d;
   logic [CNT_W-1:0]           outstanding_q, outstanding_d;
   logic                       err_q;

   // Response FIFO: storage without reset, validity comes from count_q.
   logic [IDX_W-1:0]           fifo_tag_mem   [MAX_OUTSTANDING];
   logic                       fifo_wr_mem    [MAX_OUTSTANDING];
   logic [63:0]                fifo_value_mem [MAX_OUTSTANDING];
   logic [IDX_W-1:0]           wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0]           count_q;

   logic [IDX_W-1:0]           alloc_idx;
   logic                       free_exists;
   logic                       accept;
   logic [IDX_W-1:0]           cpl_idx;
   logic                       cpl_in_range;
   logic                       push;
   logic                       cpl_bad;
   logic                       pop;
   logic [IDX_W-1:0]           head_idx;

   // ---------------- allocation ----------------
   assign free_exists = ~&bitmap_q;

   // Descending scan so the last assignment wins with the lowest free index.
   always_comb begin
      alloc_idx = '0;
      for (int i = MAX_OUTSTANDING-1; i >= 0; i--) begin
         if (!bitmap_q[i]) alloc_idx = IDX_W'(i);
      end
   end

   // Gated by rst_in so the output reads 0 while reset is held.
   assign op_ready_out = !rst_in && (state_q == ST_IDLE) && !cs_N_in && free_exists;
   assign accept       = op_valid_in && op_ready_out;

   // ---------------- completion / response ----------------
   assign cpl_idx      = lsu_completion_tag[IDX_W-1:0];
   assign cpl_in_range = ((lsu_completion_tag >> IDX_W) == '0);
   assign push         = lsu_completion_valid && cpl_in_range &&
                         bitmap_q[cpl_idx] && !completed_q[cpl_idx];
   assign cpl_bad      = lsu_completion_valid && !push;

   assign resp_valid_out = (count_q != '0);
   assign pop            = resp_valid_out && resp_ready_in;
   assign head_idx       = fifo_tag_mem[rd_ptr_q];

   // Per-tag next state. Pop, allocate and push never target the same tag in
   // one cycle: pop needs completed=1, push needs completed=0, allocate needs
   // the bitmap bit clear.
   for (genvar gi = 0; gi < MAX_OUTSTANDING; gi++) begin : g_tag
      logic pop_hit, alloc_hit, push_hit;
      assign pop_hit   = pop    && (head_idx  == IDX_W'(gi));
      assign alloc_hit = accept && (alloc_idx == IDX_W'(gi));
      assign push_hit  = push   && (cpl_idx   == IDX_W'(gi));
      assign bitmap_d[gi]       = pop_hit ? 1'b0 : (bitmap_q[gi] | alloc_hit);
      assign completed_d[gi]    = pop_hit ? 1'b0 : (completed_q[gi] | push_hit);
      assign is_write_tbl_d[gi] = alloc_hit ? op_is_write_in : is_write_tbl_q[gi];
   end

   always_comb begin
      outstanding_d = '0;
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
         outstanding_d = outstanding_d + CNT_W'(bitmap_d[i]);
      end
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         bitmap_q       <= '0;
         completed_q    <= '0;
         is_write_tbl_q <= '0;
         outstanding_q  <= '0;
         err_q          <= 1'b0;
         wr_ptr_q       <= '0;
         rd_ptr_q       <= '0;
         count_q        <= '0;
      end else begin
         bitmap_q       <= bitmap_d;
         completed_q    <= completed_d;
         is_write_tbl_q <= is_write_tbl_d;
         outstanding_q  <= outstanding_d;
         err_q          <= err_q | cpl_bad;
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({push, pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   always_ff @(posedge clk_in) begin
      if (push) begin
         fifo_tag_mem[wr_ptr_q]   <= cpl_idx;
         fifo_wr_mem[wr_ptr_q]    <= is_write_tbl_q[cpl_idx];
         fifo_value_mem[wr_ptr_q] <= lsu_completion_value;
      end
   end

   assign resp_tag_out      = resp_valid_out ? TAG_WIDTH'(head_idx)          : '0;
   assign resp_is_write_out = resp_valid_out ? fifo_wr_mem[rd_ptr_q]         : 1'b0;
   assign resp_value_out    = resp_valid_out ? fifo_value_mem[rd_ptr_q]      : '0;
   assign outstanding_out   = outstanding_q;
   assign err_spurious_out  = err_q;

   // ---------------- dispatch FSM ----------------
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_q        <= ST_IDLE;
         instr_valid_q  <= 1'b0;
         data_valid_q   <= 1'b0;
         cur_tag_q      <= '0;
         cur_is_write_q <= 1'b0;
         cur_addr_q     <= '0;
         cur_value_q    <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  cur_tag_q      <= TAG_WIDTH'(alloc_idx);
                  cur_is_write_q <= op_is_write_in;
                  cur_addr_q     <= op_addr_in;
                  cur_value_q    <= op_value_in;
                  instr_valid_q  <= 1'b1;
                  state_q        <= ST_INSTR;
               end
            end
            ST_INSTR: begin
               if (lsu_proc_instr_ready) begin
                  instr_valid_q <= 1'b0;
                  data_valid_q  <= 1'b1;
                  state_q       <= ST_DATA;
               end
            end
            ST_DATA: begin
               if (lsu_proc_data_ready) begin
                  data_valid_q <= 1'b0;
                  state_q      <= ST_IDLE;
               end
            end
            default: begin
               instr_valid_q <= 1'b0;
               data_valid_q  <= 1'b0;
               state_q       <= ST_IDLE;
            end
         endcase
      end
   end

   assign lsu_proc_instr_valid    = instr_valid_q;
   assign lsu_proc_instr_tag      = cur_tag_q;
   assign lsu_proc_instr_is_write = cur_is_write_q;
   assign lsu_proc_data_valid     = data_valid_q;
   assign lsu_proc_data_tag       = cur_tag_q;
   assign lsu_proc_addr           = cur_addr_q;
   assign lsu_proc_value          = cur_value_q;

endmodule

// File: tb/tb_lsu_dispatch_unit.sv
// -----------------------------------------------------------------------------
// tb_lsu_dispatch_unit
//   Directed bench for lsu_dispatch_unit (TAG_WIDTH=10, MAX_OUTSTANDING=8).
//   Inputs change 1 time unit after the rising edge; outputs are compared in
//   that same window, so registered results reflect the edge just taken.
// -----------------------------------------------------------------------------
module tb_lsu_dispatch_unit;

   logic        clk_in = 1'b0;
   logic        rst_in;
   logic        cs_N_in;
   logic        op_valid_in;
   logic        op_ready_out;
   logic        op_is_write_in;
   logic [63:0] op_addr_in;
   logic [63:0] op_value_in;
   logic        lsu_proc_instr_valid;
   logic [9:0]  lsu_proc_instr_tag;
   logic        lsu_proc_instr_is_write;
   logic        lsu_proc_instr_ready;
   logic        lsu_proc_data_valid;
   logic [9:0]  lsu_proc_data_tag;
   logic [63:0] lsu_proc_addr;
   logic [63:0] lsu_proc_value;
   logic        lsu_proc_data_ready;
   logic        lsu_completion_valid;
   logic [9:0]  lsu_completion_tag;
   logic [63:0] lsu_completion_value;
   logic        resp_valid_out;
   logic        resp_ready_in;
   logic [9:0]  resp_tag_out;
   logic        resp_is_write_out;
   logic [63:0] resp_value_out;
   logic [3:0]  outstanding_out;
   logic        err_spurious_out;

   int total = 0;
   int bad   = 0;

   always #5 clk_in = ~clk_in;

   lsu_dispatch_unit #(.TAG_WIDTH(10), .MAX_OUTSTANDING(8)) dut (
      .clk_in(clk_in), .rst_in(rst_in), .cs_N_in(cs_N_in),
      .op_valid_in(op_valid_in), .op_ready_out(op_ready_out),
      .op_is_write_in(op_is_write_in), .op_addr_in(op_addr_in), .op_value_in(op_value_in),
      .lsu_proc_instr_valid(lsu_proc_instr_valid), .lsu_proc_instr_tag(lsu_proc_instr_tag),
      .lsu_proc_instr_is_write(lsu_proc_instr_is_write), .lsu_proc_instr_ready(lsu_proc_instr_ready),
      .lsu_proc_data_valid(lsu_proc_data_valid), .lsu_proc_data_tag(lsu_proc_data_tag),
      .lsu_proc_addr(lsu_proc_addr), .lsu_proc_value(lsu_proc_value),
      .lsu_proc_data_ready(lsu_proc_data_ready),
      .lsu_completion_valid(lsu_completion_valid), .lsu_completion_tag(lsu_completion_tag),
      .lsu_completion_value(lsu_completion_value),
      .resp_valid_out(resp_valid_out), .resp_ready_in(resp_ready_in),
      .resp_tag_out(resp_tag_out), .resp_is_write_out(resp_is_write_out),
      .resp_value_out(resp_value_out), .outstanding_out(outstanding_out),
      .err_spurious_out(err_spurious_out)
   );

   task automatic step();
      @(posedge clk_in);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // One complete op with both LSU readies held high; checks both phases.
   task automatic do_op(input logic w, input logic [63:0] a, input logic [63:0] v,
                        input logic [9:0] et);
      op_is_write_in = w;
      op_addr_in     = a;
      op_value_in    = v;
      op_valid_in    = 1'b1;
      for (int i = 0; i < 20; i++) begin
         if (op_ready_out === 1'b1) break;
         step();
      end
      check("op_ready", {63'd0, op_ready_out}, 64'd1);
      step();
      op_valid_in = 1'b0;
      check("instr_valid", {63'd0, lsu_proc_instr_valid}, 64'd1);
      check("instr_tag", {54'd0, lsu_proc_instr_tag}, {54'd0, et});
      check("instr_is_write", {63'd0, lsu_proc_instr_is_write}, {63'd0, w});
      check("data_valid_in_instr", {63'd0, lsu_proc_data_valid}, 64'd0);
      step();
      check("data_valid", {63'd0, lsu_proc_data_valid}, 64'd1);
      check("data_tag", {54'd0, lsu_proc_data_tag}, {54'd0, et});
      check("data_addr", lsu_proc_addr, a);
      check("data_value", lsu_proc_value, v);
      step();
      check("data_done", {63'd0, lsu_proc_data_valid}, 64'd0);
      $display("op tag=%0d is_write=%0d addr=0x%0h", et, w, a);
   endtask

   task automatic complete(input logic [9:0] t, input logic [63:0] v);
      lsu_completion_valid = 1'b1;
      lsu_completion_tag   = t;
      lsu_completion_value = v;
      step();
      lsu_completion_valid = 1'b0;
      $display("completion tag=%0d value=0x%0h", t, v);
   endtask

   task automatic pop_check(input logic [9:0] et, input logic ew, input logic [63:0] ev);
      check("resp_valid", {63'd0, resp_valid_out}, 64'd1);
      check("resp_tag", {54'd0, resp_tag_out}, {54'd0, et});
      check("resp_is_write", {63'd0, resp_is_write_out}, {63'd0, ew});
      check("resp_value", resp_value_out, ev);
      resp_ready_in = 1'b1;
      step();
      resp_ready_in = 1'b0;
      $display("resp pop tag=%0d value=0x%0h", et, ev);
   endtask

   initial begin
      rst_in = 1'b1; cs_N_in = 1'b1; op_valid_in = 1'b0; op_is_write_in = 1'b0;
      op_addr_in = '0; op_value_in = '0; lsu_proc_instr_ready = 1'b0;
      lsu_proc_data_ready = 1'b0; lsu_completion_valid = 1'b0;
      lsu_completion_tag = '0; lsu_completion_value = '0; resp_ready_in = 1'b0;
      step(); step();
      check("rst_op_ready", {63'd0, op_ready_out}, 64'd0);
      check("rst_instr_valid", {63'd0, lsu_proc_instr_valid}, 64'd0);
      check("rst_resp_valid", {63'd0, resp_valid_out}, 64'd0);
      check("rst_outstanding", {60'd0, outstanding_out}, 64'd0);
      check("rst_err", {63'd0, err_spurious_out}, 64'd0);
      rst_in = 1'b0; cs_N_in = 1'b0;
      lsu_proc_instr_ready = 1'b1; lsu_proc_data_ready = 1'b1;
      step();

      // Single load then its response.
      do_op(1'b0, 64'h40, 64'h0, 10'd0);
      check("outstanding_1", {60'd0, outstanding_out}, 64'd1);
      complete(10'd0, 64'hDEAD);
      pop_check(10'd0, 1'b0, 64'hDEAD);
      check("resp_empty_1", {63'd0, resp_valid_out}, 64'd0);
      check("outstanding_0", {60'd0, outstanding_out}, 64'd0);

      // Fill all eight tags; ninth op must be refused.
      for (int i = 0; i < 8; i++) begin
         do_op(i[0], 64'h100 + 64'(i) * 8, 64'hA0 + 64'(i), 10'(i));
      end
      op_valid_in = 1'b1;
      check("full_op_ready", {63'd0, op_ready_out}, 64'd0);
      check("full_outstanding", {60'd0, outstanding_out}, 64'd8);
      step();
      check("full_no_issue", {63'd0, lsu_proc_instr_valid}, 64'd0);
      op_valid_in = 1'b0;
      $display("op 9 refused outstanding=%0d", outstanding_out);

      // Completions 5 then 2 with core not ready; responses in completion order.
      complete(10'd5, 64'h5555);
      complete(10'd2, 64'h2222);
      check("fifo_hold_outstanding", {60'd0, outstanding_out}, 64'd8);
      pop_check(10'd5, 1'b1, 64'h5555);
      pop_check(10'd2, 1'b0, 64'h2222);
      check("resp_empty_2", {63'd0, resp_valid_out}, 64'd0);
      check("outstanding_6", {60'd0, outstanding_out}, 64'd6);
      do_op(1'b1, 64'h200, 64'h99, 10'd2);

      // Push and pop in the same cycle.
      complete(10'd0, 64'hAAAA);
      lsu_completion_valid = 1'b1; lsu_completion_tag = 10'd1;
      lsu_completion_value = 64'hBBBB; resp_ready_in = 1'b1;
      step();
      lsu_completion_valid = 1'b0; resp_ready_in = 1'b0;
      $display("push tag=1 with pop tag=0");
      pop_check(10'd1, 1'b1, 64'hBBBB);
      check("resp_empty_3", {63'd0, resp_valid_out}, 64'd0);
      check("outstanding_5", {60'd0, outstanding_out}, 64'd5);

      // Instruction phase held off 4 cycles; cs_N high mid-op does not abort.
      lsu_proc_instr_ready = 1'b0; lsu_proc_data_ready = 1'b0;
      op_is_write_in = 1'b1; op_addr_in = 64'h1000; op_value_in = 64'h55;
      op_valid_in = 1'b1;
      step();
      op_valid_in = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (i == 1) cs_N_in = 1'b1;
         check("stall_instr_valid", {63'd0, lsu_proc_instr_valid}, 64'd1);
         check("stall_instr_tag", {54'd0, lsu_proc_instr_tag}, 64'd0);
         check("stall_data_valid", {63'd0, lsu_proc_data_valid}, 64'd0);
         $display("stall cycle %0d instr_valid=%0d", i, lsu_proc_instr_valid);
         step();
      end
      lsu_proc_instr_ready = 1'b1;
      step();
      lsu_proc_instr_ready = 1'b0;
      check("stall_data_phase", {63'd0, lsu_proc_data_valid}, 64'd1);
      check("stall_data_addr", lsu_proc_addr, 64'h1000);
      // Completion arrives while tag 0 is still in data phase.
      complete(10'd0, 64'h77);
      check("early_cpl_data_valid", {63'd0, lsu_proc_data_valid}, 64'd1);
      check("early_cpl_err", {63'd0, err_spurious_out}, 64'd0);
      lsu_proc_data_ready = 1'b1;
      step();
      check("stall_data_done", {63'd0, lsu_proc_data_valid}, 64'd0);
      cs_N_in = 1'b0;
      pop_check(10'd0, 1'b1, 64'h77);

      // Spurious completions: freed tag, out-of-range tag; flag is sticky.
      complete(10'd0, 64'h1);
      check("spur_no_resp", {63'd0, resp_valid_out}, 64'd0);
      check("spur_err", {63'd0, err_spurious_out}, 64'd1);
      complete(10'd8, 64'h2);
      step(); step();
      check("spur_no_resp_2", {63'd0, resp_valid_out}, 64'd0);
      check("spur_err_sticky", {63'd0, err_spurious_out}, 64'd1);

      // Reset during data phase with tags outstanding.
      lsu_proc_instr_ready = 1'b1; lsu_proc_data_ready = 1'b0;
      op_is_write_in = 1'b0; op_addr_in = 64'h3000; op_valid_in = 1'b1;
      step();
      op_valid_in = 1'b0;
      step();
      check("pre_rst_data_valid", {63'd0, lsu_proc_data_valid}, 64'd1);
      check("pre_rst_outstanding", {60'd0, outstanding_out}, 64'd6);
      rst_in = 1'b1;
      #1;
      check("async_rst_data_valid", {63'd0, lsu_proc_data_valid}, 64'd0);
      check("async_rst_addr", lsu_proc_addr, 64'd0);
      check("async_rst_outstanding", {60'd0, outstanding_out}, 64'd0);
      check("async_rst_err", {63'd0, err_spurious_out}, 64'd0);
      check("async_rst_op_ready", {63'd0, op_ready_out}, 64'd0);
      $display("reset asserted mid data phase");
      complete(10'd3, 64'h33);
      check("rst_cpl_ignored", {63'd0, resp_valid_out}, 64'd0);
      rst_in = 1'b0;
      step();
      complete(10'd6, 64'h66);
      check("post_rst_spur_resp", {63'd0, resp_valid_out}, 64'd0);
      check("post_rst_spur_err", {63'd0, err_spurious_out}, 64'd1);
      lsu_proc_data_ready = 1'b1;
      do_op(1'b0, 64'h80, 64'h0, 10'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
